// File: rtl/usr_pkg.sv
// usr_pkg: mode codes and widths shared by the universal shift register and its bench
package usr_pkg;
  localparam int MODE_W = 3;
  localparam logic [MODE_W-1:0] MODE_HOLD = 3'd0;
  localparam logic [MODE_W-1:0] MODE_SHL  = 3'd1;
  localparam logic [MODE_W-1:0] MODE_SHR  = 3'd2;
  localparam logic [MODE_W-1:0] MODE_ROL  = 3'd3;
  localparam logic [MODE_W-1:0] MODE_ROR  = 3'd4;
  localparam logic [MODE_W-1:0] MODE_ASR  = 3'd5;
  localparam logic [MODE_W-1:0] MODE_LOAD = 3'd6;
  localparam logic [MODE_W-1:0] MODE_CLR  = 3'd7;
endpackage

// File: rtl/usr_fill_counter.sv
// usr_fill_counter: saturating count of serial bits held, with load-to-full and clear
module usr_fill_counter #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             set_full,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             full
);
  localparam logic [CNT_W-1:0] MAX = CNT_W'(WIDTH);
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  // clear wins over load, load over increment; increments stop at WIDTH
  always_comb begin
    count_d = clr ? '0 : set_full ? MAX : (inc && count_q != MAX) ? count_q + 1'b1 : count_q;
    full_d  = count_d == MAX;
  end
  // registered count and flag, both cleared by active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      full_q  <= full_d;
    end
  end
  assign count = count_q;
  assign full  = full_q;
endmodule

// File: rtl/universal_shift_register.sv
// universal_shift_register: shift/rotate/load/clear register with fill tracking; USR_PARITY_EN adds a parity output
module universal_shift_register
  import usr_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [MODE_W-1:0] mode,
  input  logic              in_bit,
  input  logic [WIDTH-1:0]  d,
  output logic [WIDTH-1:0]  q,
  output logic              ser_out,
  output logic [CNT_W-1:0]  fill_cnt,
`ifdef USR_PARITY_EN
  output logic              parity,
`endif
  output logic              full
);
  logic [WIDTH-1:0] q_q, q_d;
  logic             ser_out_q, ser_out_d;
  // next register value and outgoing bit for the selected operation
  always_comb begin
    q_d       = q_q;
    ser_out_d = ser_out_q;
    if (en)
      case (mode)
        MODE_SHL:  begin q_d = {q_q[WIDTH-2:0], in_bit};   ser_out_d = q_q[WIDTH-1]; end
        MODE_SHR:  begin q_d = {in_bit, q_q[WIDTH-1:1]};   ser_out_d = q_q[0];       end
        MODE_ROL:  begin q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]}; ser_out_d = q_q[WIDTH-1]; end
        MODE_ROR:  begin q_d = {q_q[0], q_q[WIDTH-1:1]};   ser_out_d = q_q[0];       end
        MODE_ASR:  begin q_d = {q_q[WIDTH-1], q_q[WIDTH-1:1]}; ser_out_d = q_q[0];   end
        MODE_LOAD: q_d = d;
        MODE_CLR:  begin q_d = '0; ser_out_d = 1'b0; end
        default:   ;
      endcase
  end
  // register contents and last shifted-out bit
  always_ff @(posedge clk) begin
    if (!rst) begin
      q_q       <= '0;
      ser_out_q <= 1'b0;
    end else begin
      q_q       <= q_d;
      ser_out_q <= ser_out_d;
    end
  end
`ifdef USR_PARITY_EN
  logic parity_q, parity_d;
  // parity of the next contents so it tracks q without lag; holds with q when disabled
  always_comb parity_d = ^q_d;
  // registered parity, cleared by reset
  always_ff @(posedge clk) begin
    if (!rst) parity_q <= 1'b0;
    else      parity_q <= parity_d;
  end
  assign parity = parity_q;
`endif
  usr_fill_counter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_fill (
    .clk      (clk),
    .rst      (rst),
    .inc      (en && (mode == MODE_SHL || mode == MODE_SHR)),
    .set_full (en && mode == MODE_LOAD),
    .clr      (en && mode == MODE_CLR),
    .count    (fill_cnt),
    .full     (full)
  );
  assign q       = q_q;
  assign ser_out = ser_out_q;
endmodule

// File: tb/tb_universal_shift_register.sv
// tb_universal_shift_register: directed vectors checked against an arithmetic reference model every cycle
module tb_universal_shift_register;
  import usr_pkg::*;
  localparam int W = 4;
  localparam int CW = $clog2(W + 1);
  logic clk = 1'b0, rst = 1'b0, en = 1'b0, in_bit = 1'b0;
  logic [MODE_W-1:0] mode = MODE_HOLD;
  logic [W-1:0] d = '0, q;
  logic ser_out, full;
  logic [CW-1:0] fill_cnt;
`ifdef USR_PARITY_EN
  logic parity;
`endif
  int total = 0, bad = 0;
  int mq = 0, mso = 0, mcnt = 0;
  bit mvalid = 0;
  universal_shift_register #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .in_bit(in_bit), .d(d),
    .q(q), .ser_out(ser_out), .fill_cnt(fill_cnt),
`ifdef USR_PARITY_EN
    .parity(parity),
`endif
    .full(full)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // reference model: register as an integer, updated with plain arithmetic
  always @(posedge clk) begin
    int mask, top;
    mask = (1 << W) - 1;
    top = (mq >> (W - 1)) & 1;
    if (!rst) begin
      mq = 0; mso = 0; mcnt = 0; mvalid = 1;
    end else if (en) begin
      case (int'(mode))
        1: begin mso = top;    mq = ((mq << 1) | int'(in_bit)) & mask;      mcnt = (mcnt < W) ? mcnt + 1 : W; end
        2: begin mso = mq & 1; mq = (mq >> 1) | (int'(in_bit) << (W - 1)); mcnt = (mcnt < W) ? mcnt + 1 : W; end
        3: begin mso = top;    mq = ((mq << 1) | top) & mask; end
        4: begin mso = mq & 1; mq = (mq >> 1) | ((mq & 1) << (W - 1)); end
        5: begin mso = mq & 1; mq = (mq >> 1) | (top << (W - 1)); end
        6: begin mq = int'(d); mcnt = W; end
        7: begin mq = 0; mso = 0; mcnt = 0; end
        default: ;
      endcase
    end
  end
  // compare all outputs against the model away from the active edge
  always @(negedge clk) begin
    if (mvalid) begin
      chk("m_q", int'(q), mq);
      chk("m_ser_out", int'(ser_out), mso);
      chk("m_fill_cnt", int'(fill_cnt), mcnt);
      chk("m_full", int'(full), int'(mcnt == W));
`ifdef USR_PARITY_EN
      chk("m_parity", int'(parity), $countones(mq) % 2);
`endif
    end
  end
  task automatic step(input logic e, input logic [MODE_W-1:0] m, input logic b, input logic [W-1:0] dd);
    en = e; mode = m; in_bit = b; d = dd;
    @(posedge clk);
    #1;
  endtask
  initial begin
    en = 1'b1; mode = MODE_LOAD; d = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_q", int'(q), 0);
    chk("rst_fill", int'(fill_cnt), 0);
    chk("rst_full", int'(full), 0);
    chk("rst_ser", int'(ser_out), 0);
    rst = 1'b1;
    step(1, MODE_SHL, 1, 0); chk("shl1_q", int'(q), 1);  chk("shl1_cnt", int'(fill_cnt), 1);
    step(1, MODE_SHL, 1, 0); chk("shl2_q", int'(q), 3);  chk("shl2_cnt", int'(fill_cnt), 2);
    step(1, MODE_SHL, 0, 0); chk("shl3_q", int'(q), 6);  chk("shl3_cnt", int'(fill_cnt), 3); chk("shl3_full", int'(full), 0);
    step(1, MODE_SHL, 1, 0); chk("shl4_q", int'(q), 13); chk("shl4_cnt", int'(fill_cnt), 4); chk("shl4_full", int'(full), 1);
    step(1, MODE_LOAD, 0, 4'b1001); chk("load_q", int'(q), 9);
    step(1, MODE_ROL, 0, 0); chk("rol1_q", int'(q), 3); chk("rol1_ser", int'(ser_out), 1); chk("rol1_cnt", int'(fill_cnt), 4);
    step(1, MODE_ROL, 0, 0); chk("rol2_q", int'(q), 6); chk("rol2_ser", int'(ser_out), 0); chk("rol2_cnt", int'(fill_cnt), 4);
    step(1, MODE_LOAD, 0, 4'b1000);
    step(1, MODE_ASR, 0, 0); chk("asr1_q", int'(q), 12); chk("asr1_ser", int'(ser_out), 0);
    step(1, MODE_ASR, 0, 0); chk("asr2_q", int'(q), 14); chk("asr2_ser", int'(ser_out), 0);
    step(1, MODE_SHR, 0, 0); chk("shr_q", int'(q), 7); chk("shr_ser", int'(ser_out), 0);
    step(1, MODE_CLR, 0, 0);
    repeat (4) step(1, MODE_SHL, 1, 0);
    chk("fill_q", int'(q), 15); chk("fill_full", int'(full), 1);
    step(1, MODE_SHL, 0, 0); chk("sat_q", int'(q), 14); chk("sat_ser", int'(ser_out), 1); chk("sat_cnt", int'(fill_cnt), 4);
    for (int i = 0; i < 3; i++) begin
      step(0, MODE_CLR, 1, 4'h5);
      chk("hold_q", int'(q), 14); chk("hold_ser", int'(ser_out), 1); chk("hold_cnt", int'(fill_cnt), 4); chk("hold_full", int'(full), 1);
    end
    step(1, MODE_CLR, 0, 0);
    step(1, MODE_SHL, 1, 0);
    step(1, MODE_SHL, 1, 0);
    step(1, MODE_ROR, 0, 0); chk("ror_q", int'(q), 9); chk("ror_ser", int'(ser_out), 1); chk("ror_cnt", int'(fill_cnt), 2);
    rst = 1'b0;
    step(1, MODE_LOAD, 0, 4'hF);
    chk("mid_q", int'(q), 0); chk("mid_cnt", int'(fill_cnt), 0); chk("mid_full", int'(full), 0); chk("mid_ser", int'(ser_out), 0);
    rst = 1'b1;
    step(1, MODE_LOAD, 0, 4'b0101);
    step(1, MODE_CLR, 0, 0);
    chk("clr_q", int'(q), 0); chk("clr_cnt", int'(fill_cnt), 0); chk("clr_full", int'(full), 0); chk("clr_ser", int'(ser_out), 0);
`ifdef USR_PARITY_EN
    step(1, MODE_LOAD, 0, 4'b0111); chk("par_load", int'(parity), 1);
    step(1, MODE_SHL, 0, 0); chk("par_shl_q", int'(q), 14); chk("par_shl", int'(parity), 1);
    step(1, MODE_CLR, 0, 0); chk("par_clr", int'(parity), 0);
`endif
    for (int m = 0; m < 8; m++) begin
      step(1, MODE_LOAD, 0, 4'b1011);
      step(1, MODE_W'(m), m[0], 4'b0110);
      step(1, MODE_W'(m), ~m[1], 4'b0011);
    end
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
